// File: rtl/pf_iod_lvds_tx_pkg.sv
// Shared types and constants for the PolarFire LVDS TX lane sequencer.
package pf_iod_lvds_tx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PAUSE     = 3'd1,
        ST_SYNC_RST  = 3'd2,
        ST_TRAIN     = 3'd3,
        ST_DATA      = 3'd4
    } tx_state_e;

    localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h0F;
    localparam logic [7:0] IDLE_PATTERN_DEF  = 8'h00;

    // The counter is loaded with count-1, so it never has to hold max_count itself.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/pf_iod_lvds_tx_lane_seq_if.sv
// User word stream into the TX lane sequencer (valid/ready, no backpressure in DATA).
interface pf_iod_lvds_tx_lane_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] S_DATA;
    logic                  S_VALID;
    logic                  S_READY;

    modport master (output S_DATA, output S_VALID, input  S_READY);
    modport slave  (input  S_DATA, input  S_VALID, output S_READY);
endinterface

// File: rtl/pf_iod_lvds_tx_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the fabric clock domain.
module pf_iod_lvds_tx_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    // Synchronizer chain, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/pf_iod_lvds_tx_lane_seq.sv
// Bring-up sequencer and word launcher for one PolarFire LVDS TX lane:
// lock -> clock pause -> gearbox sync reset -> training -> user data.
module pf_iod_lvds_tx_lane_seq
    import pf_iod_lvds_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    PAUSE_CYCLES    = 4,
    parameter int                    SYNC_RST_CYCLES = 8,
    parameter int                    TRAIN_WORDS     = 64,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN   = DATA_WIDTH'(TRAIN_PATTERN_DEF),
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN    = DATA_WIDTH'(IDLE_PATTERN_DEF)
) (
    input  logic                      FAB_CLK,
    input  logic                      RESET,
    input  logic                      PLL_LOCK,
    input  logic                      TX_EN,
    pf_iod_lvds_tx_lane_seq_if.slave  s_if,
    output logic                      HS_IO_CLK_PAUSE,
    output logic                      TX_SYNC_RST,
    output logic [DATA_WIDTH-1:0]     TXD,
    output logic                      LINK_UP
);
    localparam int MAX_A   = (PAUSE_CYCLES > SYNC_RST_CYCLES) ? PAUSE_CYCLES : SYNC_RST_CYCLES;
    localparam int MAX_CNT = (MAX_A > TRAIN_WORDS) ? MAX_A : TRAIN_WORDS;
    localparam int CW      = cnt_width(MAX_CNT);

    localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
    localparam logic [CW-1:0] SYNC_LOAD  = CW'(SYNC_RST_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LOAD = CW'(TRAIN_WORDS - 1);

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pause_q, pause_d;
    logic                  sync_rst_q, sync_rst_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  s_ready_q, s_ready_d;
    logic                  link_up_q, link_up_d;
    logic                  lock_s;
    logic                  lock_ok;

    pf_iod_lvds_tx_lock_sync u_lock_sync (
        .clk_i   (FAB_CLK),
        .rst_i   (RESET),
        .async_i (PLL_LOCK),
        .sync_o  (lock_s)
    );

    assign lock_ok = lock_s & TX_EN;

    // State, counter and output registers; outputs follow the next state on the same edge.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            pause_q    <= 1'b1;
            sync_rst_q <= 1'b1;
            txd_q      <= '0;
            s_ready_q  <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pause_q    <= pause_d;
            sync_rst_q <= sync_rst_d;
            txd_q      <= txd_d;
            s_ready_q  <= s_ready_d;
            link_up_q  <= link_up_d;
        end
    end

    // Next-state logic; losing lock or enable wins over any count expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_ok) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_PAUSE;
                    cnt_d   = PAUSE_LOAD;
                end
                ST_PAUSE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SYNC_RST;
                        cnt_d   = SYNC_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_SYNC_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_TRAIN;
                        cnt_d   = TRAIN_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_TRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state; a TRAIN entry always restarts on the true pattern.
    always_comb begin
        pause_d    = 1'b1;
        sync_rst_d = 1'b1;
        txd_d      = '0;
        s_ready_d  = 1'b0;
        link_up_d  = 1'b0;
        case (state_d)
            ST_WAIT_LOCK: begin
                pause_d    = 1'b1;
                sync_rst_d = 1'b1;
            end
            ST_PAUSE: begin
                pause_d    = 1'b1;
                sync_rst_d = 1'b0;
            end
            ST_SYNC_RST: begin
                pause_d    = 1'b1;
                sync_rst_d = 1'b1;
            end
            ST_TRAIN: begin
                pause_d    = 1'b0;
                sync_rst_d = 1'b0;
                if ((state_q == ST_TRAIN) && (txd_q == TRAIN_PATTERN)) begin
                    txd_d = ~TRAIN_PATTERN;
                end else begin
                    txd_d = TRAIN_PATTERN;
                end
            end
            ST_DATA: begin
                pause_d    = 1'b0;
                sync_rst_d = 1'b0;
                s_ready_d  = 1'b1;
                link_up_d  = 1'b1;
                if (s_ready_q && s_if.S_VALID) begin
                    txd_d = s_if.S_DATA;
                end else begin
                    txd_d = IDLE_PATTERN;
                end
            end
            default: begin
                pause_d    = 1'b1;
                sync_rst_d = 1'b1;
            end
        endcase
    end

    assign HS_IO_CLK_PAUSE = pause_q;
    assign TX_SYNC_RST     = sync_rst_q;
    assign TXD             = txd_q;
    assign LINK_UP         = link_up_q;
    assign s_if.S_READY    = s_ready_q;
endmodule

// File: tb/tb_pf_iod_lvds_tx_lane_seq.sv
// Directed bench for the LVDS TX lane sequencer: bring-up timing, training, data, aborts, reset.
module tb_pf_iod_lvds_tx_lane_seq;
    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       tx_en;
    logic       hs_pause;
    logic       sync_rst;
    logic [7:0] txd;
    logic       link_up;

    int checks   = 0;
    int failures = 0;
    int cur_edge = 0;

    pf_iod_lvds_tx_lane_seq_if #(.DATA_WIDTH(8)) s_bus ();

    pf_iod_lvds_tx_lane_seq dut (
        .FAB_CLK         (clk),
        .RESET           (rst),
        .PLL_LOCK        (pll_lock),
        .TX_EN           (tx_en),
        .s_if            (s_bus),
        .HS_IO_CLK_PAUSE (hs_pause),
        .TX_SYNC_RST     (sync_rst),
        .TXD             (txd),
        .LINK_UP         (link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s edge=%0d observed=%0h expected=%0h", tag, cur_edge, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pause"}, 32'(hs_pause), 32'd1);
        chk({tag, "_srst"},  32'(sync_rst), 32'd1);
        chk({tag, "_txd"},   32'(txd), 32'h00);
        chk({tag, "_ready"}, 32'(s_bus.S_READY), 32'd0);
        chk({tag, "_link"},  32'(link_up), 32'd0);
    endtask

    // Edge e counted from the lock rise (e=1 is the first edge that samples it).
    task automatic check_seq(input int first, input int last);
        logic       exp_p;
        logic       exp_r;
        logic       exp_l;
        logic [7:0] exp_d;
        for (int e = first; e <= last; e++) begin
            tick();
            cur_edge = e;
            exp_p = (e < 15);
            exp_r = (e < 3) || ((e >= 7) && (e < 15));
            exp_l = (e >= 79);
            if ((e < 15) || (e >= 79)) exp_d = 8'h00;
            else exp_d = (((e - 15) % 2) == 0) ? 8'h0F : 8'hF0;
            chk("seq_pause", 32'(hs_pause), 32'(exp_p));
            chk("seq_srst",  32'(sync_rst), 32'(exp_r));
            chk("seq_link",  32'(link_up),  32'(exp_l));
            chk("seq_ready", 32'(s_bus.S_READY), 32'(exp_l));
            chk("seq_txd",   32'(txd), 32'(exp_d));
        end
    endtask

    initial begin
        rst           = 1'b1;
        pll_lock      = 1'b0;
        tx_en         = 1'b1;
        s_bus.S_DATA  = 8'h00;
        s_bus.S_VALID = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk_idle_outputs("nolock");

        // 1/2: full bring-up and training from the lock rise
        pll_lock = 1'b1;
        check_seq(1, 79);

        // 3: stream 01..10, then two idle cycles
        for (int k = 1; k <= 16; k++) begin
            s_bus.S_DATA  = 8'(k);
            s_bus.S_VALID = 1'b1;
            tick();
            cur_edge = 100 + k;
            chk("data_txd",   32'(txd), 32'(k));
            chk("data_ready", 32'(s_bus.S_READY), 32'd1);
        end
        s_bus.S_VALID = 1'b0;
        s_bus.S_DATA  = 8'hAA;
        tick();
        chk("idle0_txd", 32'(txd), 32'h00);
        tick();
        chk("idle1_txd", 32'(txd), 32'h00);

        // 4: lock loss in DATA takes three edges
        pll_lock = 1'b0;
        tick();
        cur_edge = 201;
        chk("lockdrop1_link", 32'(link_up), 32'd1);
        tick();
        cur_edge = 202;
        chk("lockdrop2_link", 32'(link_up), 32'd1);
        tick();
        cur_edge = 203;
        chk_idle_outputs("lockdrop3");
        pll_lock = 1'b1;
        check_seq(1, 79);

        // 5: TX_EN drop in mid SYNC_RST, then immediate re-enable
        tx_en = 1'b0;
        tick();
        cur_edge = 301;
        chk_idle_outputs("txen_off");
        tx_en = 1'b1;
        check_seq(3, 9);
        tx_en = 1'b0;
        tick();
        cur_edge = 310;
        chk_idle_outputs("txen_syncrst");
        tx_en = 1'b1;
        check_seq(3, 40);

        // 6: one-cycle reset in mid TRAIN
        rst = 1'b1;
        tick();
        cur_edge = 400;
        chk_idle_outputs("midreset");
        rst = 1'b0;
        check_seq(1, 79);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
